fir_mac_filter: RTL

//   Parametrised N-tap FIR filter, direct form, one shared signed MAC.

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_coef_bank.sv | 47 ++++
 rtl/fir_mac_filter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the shared-MAC FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    // Working width for saturation; the accumulator is sign-extended into it.
    localparam int SAT_W = 64;

    // Accumulator width: full product plus enough headroom to sum every tap.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Clamp a wide signed value into the signed range of data_w bits.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] val,
        input int                      data_w
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (data_w - 1));
        if (val > max_v) begin
            return max_v;
        end else if (val < min_v) begin
            return min_v;
        end
        return val;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Runtime-loadable coefficient register file with write range/idle check.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int IDX_W  = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr,
    input  logic                     i_wr_allow,
    input  logic        [IDX_W-1:0]  i_addr,
    input  logic signed [COEF_W-1:0] i_data,
    input  logic        [IDX_W-1:0]  i_rd_idx,
    output logic signed [COEF_W-1:0] o_rd_data,
    output logic                     o_err
);

    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic                     r_err;
    logic                     w_in_range;
    logic                     w_accept;

    // The index port may be wider than needed when TAPS is not a power of two.
    assign w_in_range = (32'(i_addr) < TAPS);
    assign w_accept   = i_wr & i_wr_allow & w_in_range;

    // Coefficient storage and one-cycle rejection pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            r_err <= i_wr & ~w_accept;
            if (w_accept) begin
                r_coef[i_addr] <= i_data;
            end
        end
    end

    assign o_rd_data = r_coef[i_rd_idx];
    assign o_err     = r_err;

endmodule

// File: rtl/fir_mac_filter.sv
// Direct-form N-tap FIR: one sample in, TAPS serial MAC cycles, one result out.
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int SHIFT  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_coef_wr,
    input  logic [$clog2(TAPS)-1:0]    i_coef_addr,
    input  logic signed [COEF_W-1:0]   i_coef_data,
    output logic                       o_coef_err,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic signed [DATA_W-1:0]   i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic signed [DATA_W-1:0]   o_out_data,
    output logic                       o_busy
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int IDX_W = $clog2(TAPS);

    fir_state_t               r_state;
    logic signed [DATA_W-1:0] r_x [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic        [IDX_W-1:0]  r_idx;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_busy;

    logic signed [COEF_W-1:0] w_coef;
    logic signed [ACC_W-1:0]  w_x_ext;
    logic signed [ACC_W-1:0]  w_c_ext;
    logic signed [ACC_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [SAT_W-1:0]  w_sat;
    logic                     w_last_tap;
    logic                     w_idle;
    logic [SAT_W-DATA_W-1:0]  w_unused_sat_hi;

    assign w_idle = (r_state == IDLE);

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .IDX_W  (IDX_W)
    ) u_coef_bank (
        .clk        (clk),
        .rst        (rst),
        .i_wr       (i_coef_wr),
        .i_wr_allow (w_idle),
        .i_addr     (i_coef_addr),
        .i_data     (i_coef_data),
        .i_rd_idx   (r_idx),
        .o_rd_data  (w_coef),
        .o_err      (o_coef_err)
    );

    // Operands are sign-extended to the accumulator width, so the product
    // and the running sum can never wrap.
    assign w_x_ext    = ACC_W'(r_x[r_idx]);
    assign w_c_ext    = ACC_W'(w_coef);
    assign w_prod     = w_x_ext * w_c_ext;
    assign w_acc_next = r_acc + w_prod;
    assign w_shifted  = w_acc_next >>> SHIFT;
    assign w_last_tap = (r_idx == IDX_W'(TAPS - 1));

    // The final term is folded in on the same edge that registers the result.
    assign w_sat           = saturate(SAT_W'(w_shifted), DATA_W);
    assign w_unused_sat_hi = w_sat[SAT_W-1:DATA_W];

    // Sequencer: sample capture, serial MAC over all taps, output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
            r_acc       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_x[0] <= i_in_data;
                        for (int k = TAPS - 1; k > 0; k--) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    if (w_last_tap) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sat[DATA_W-1:0];
                        r_state     <= OUT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_busy      = r_busy;

endmodule
